ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit for the EX stage; supplies the mult/multu/div/divu ops the combinational ALU lacks.
//  Owns the architectural HI/LO registers, also written directly by mthi/mtlo.
//  Takes a one-cycle start pulse, holds busy while computing, pulses done when HI/LO hold the result.
//  The pipeline stalls EX on busy; an exception flush drives cancel.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are WIDTH bits each; product is 2*WIDTH
//  CNT_W  $clog2(WIDTH+1)  iteration counter width (derived, not overridden)
// PORTS
//  clk      in   1      clock, rising edge
//  resetn   in   1      asynchronous active-low reset
//  start    in   1      launch op; sampled only in IDLE
//  op       in   2      MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3
//  src1     in   WIDTH  multiplicand / dividend (rs)
//  src2     in   WIDTH  multiplier / divisor (rt)
//  cancel   in   1      flush: abort in-flight op, HI/LO untouched
//  hi_we    in   1      mthi write enable
//  lo_we    in   1      mtlo write enable
//  wdata    in   WIDTH  mthi/mtlo data
//  busy     out  1      state != IDLE
//  done     out  1      one-cycle pulse: HI/LO now hold the result
//  hi       out  WIDTH  HI register
//  lo       out  WIDTH  LO register
// BEHAVIOUR
//  - Reset (resetn=0, async): state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, datapath regs=0.
//  - States: IDLE -> CALC (WIDTH cycles) -> FIX (1 cycle) -> IDLE.
//  - IDLE, start=1, cancel=0: latch |src1|, |src2|, op, result signs. Magnitudes are taken only for MD_MULT/MD_DIV.
//  - IDLE to CALC transition: counter=WIDTH.
//  - CALC, multiply: radix-2 shift-add, one multiplier bit per cycle into a 2*WIDTH accumulator.
//  - CALC, divide: restoring shift-subtract, one quotient bit per cycle.
//  - CALC: counter decrements each cycle; at counter==1 go to FIX.
//  - FIX, multiply: negate the 2*WIDTH product if the signs differ. HI=product[2W-1:W], LO=product[W-1:0].
//  - FIX, divide: quotient sign = src1 sign XOR src2 sign; remainder sign = src1 sign. LO=quotient, HI=remainder.
//  - FIX writes HI/LO at its closing edge; done=1 in the following cycle (state IDLE).
//  - Latency: start sampled at edge E0; busy=1 after E0 through E(WIDTH+1). done=1 and HI/LO valid in the cycle after E(WIDTH+1).
//  - Start-to-done latency is WIDTH+2 cycles for every op.
//  - Divide by zero (all ops): LO={WIDTH{1}}, HI=src1 as supplied. No sign fix, same latency.
//  - Signed overflow (most-negative / -1): LO=most-negative (wraps), HI=0.
//  - start while busy: ignored. Back-to-back: start accepted in the IDLE cycle where done=1.
//  - cancel (any state): next edge state=IDLE, no HI/LO write, done stays 0.
//  - cancel with start in the same cycle: start is dropped.
//  - hi_we/lo_we in IDLE: write wdata at the edge. Same cycle as an accepted start: the write lands now, the op result overwrites later.
//  - hi_we/lo_we while busy: ignored; the pipeline must stall the mthi/mtlo instead. The bench flags it as an error.
//  - Reset mid-op: immediate IDLE; all outputs go to their reset values.
// STRUCTURE
//  - muldiv_pkg holds: MD_* op encodings, state enum (IDLE/CALC/FIX), the WIDTH default constant.
//  - The ALU and decoder import muldiv_pkg for op encodings.
//  - Sub-module muldiv_iter_core: shift-add/shift-subtract datapath and counter.
//  - The top holds the FSM, sign handling, HI/LO registers and the mthi/mtlo port.
// TESTING
//  - MULT -3 * 7: after WIDTH+2 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFEB, done pulses exactly once.
//  - MULTU 0xFFFFFFFF * 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
//  - DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  - DIVU 100 / 7 -> LO=14, HI=2.
//  - DIV 5 / 0 -> LO=0xFFFFFFFF, HI=5.
//  - DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
//  - Start DIVU 100/7, assert cancel at CALC cycle 10:
//    - next cycle busy=0; HI/LO keep the prior values; no done pulse.
//    - a new MULTU 6*7 started next gives LO=42, HI=0.
//  - mtlo 0x1234 in IDLE -> lo=0x1234 next cycle. During busy: hi_we=1 with wdata=0xDEAD is ignored, start re-pulse is ignored.
//  - resetn low at CALC cycle 5: all outputs 0 asynchronously; clean op afterwards.
//  - Random: 10k signed/unsigned ops vs reference model, incl. zero, ±1, min/max operands.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes, FSM states, default width.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    function automatic logic md_is_div(input md_op_e op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: radix-2 shift-add multiply or restoring shift-subtract divide,
// one bit per step, on unsigned magnitudes. Also owns the iteration counter.
module muldiv_iter_core #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);

    logic [WIDTH-1:0] opnd;
    logic             div_mode;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // acc_lo holds the unconsumed multiplier bits (multiply) or the dividend
    // bits still to be shifted in, replaced by quotient bits (divide).
    assign sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign shifted = {acc_hi, acc_lo[WIDTH-1]};
    assign diff    = shifted - {1'b0, opnd};

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            cnt      <= CNT_W'(WIDTH);
            div_mode <= is_div;
            acc_hi   <= '0;
            acc_lo   <= is_div ? a : b;
            opnd     <= is_div ? b : a;
        end else if (step) begin
            cnt <= cnt - CNT_W'(1);
            if (!div_mode) begin
                {acc_hi, acc_lo} <= {sum, acc_lo[WIDTH-1:1]};
            end else if (!diff[WIDTH]) begin
                acc_hi <= diff[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi <= shifted[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: FSM, sign handling, architectural HI/LO and mthi/mtlo.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter  int WIDTH = MD_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e        state, state_next;
    md_op_e           op_in, op_q;
    logic             accept;
    logic             sign1, sign2;
    logic [WIDTH-1:0] mag1, mag2;
    logic             neg_q, neg_r, div0;
    logic [WIDTH-1:0] src1_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             commit;

    assign op_in  = md_op_e'(op);
    assign accept = (state == IDLE) && start && !cancel;
    assign busy   = (state != IDLE);
    assign commit = (state == FIX) && !cancel;

    assign sign1 = md_is_signed(op_in) && src1[WIDTH-1];
    assign sign2 = md_is_signed(op_in) && src2[WIDTH-1];
    assign mag1  = sign1 ? -src1 : src1;
    assign mag2  = sign2 ? -src2 : src2;

    muldiv_iter_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk    (clk),
        .resetn (resetn),
        .load   (accept),
        .step   (state == CALC),
        .is_div (md_is_div(op_in)),
        .a      (mag1),
        .b      (mag2),
        .cnt    (cnt),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo)
    );

    // NOTE: combinational blocks assign every output a default first, so no
    // path through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (cnt == CNT_W'(1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (cancel) state_next = IDLE;
    end

    assign product = {acc_hi, acc_lo};

    always_comb begin
        res_hi = acc_hi;
        res_lo = acc_lo;
        if (!md_is_div(op_q)) begin
            {res_hi, res_lo} = neg_q ? -product : product;
        end else if (div0) begin
            res_hi = src1_q;
            res_lo = '1;
        end else begin
            res_lo = neg_q ? -acc_lo : acc_lo;
            res_hi = neg_r ? -acc_hi : acc_hi;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            op_q   <= MD_MULT;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            src1_q <= '0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state <= state_next;
            done  <= commit;
            if (accept) begin
                op_q   <= op_in;
                neg_q  <= sign1 ^ sign2;
                neg_r  <= sign1;
                div0   <= md_is_div(op_in) && (src2 == '0);
                src1_q <= src1;
            end
            // mthi/mtlo only land in IDLE; a flushed move is dropped like a flushed op.
            if (commit) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if ((state == IDLE) && !cancel) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: cycle-level behavioural model plus literal expectations.
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] src1 = '0;
    logic [W-1:0] src2 = '0;
    logic         cancel = 1'b0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .src1   (src1),
        .src2   (src2),
        .cancel (cancel),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {hi, lo} from plain arithmetic.
    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sa, sb;
        logic [63:0]  ua, ub, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            2'd0: return 64'(sa * sb);
            2'd1: return ua * ub;
            default: begin
                if (b == '0) return {a, {W{1'b1}}};
                if (o == 2'd2) begin
                    q = 64'(sa / sb);
                    r = 64'(sa % sb);
                end else begin
                    q = ua / ub;
                    r = ua % ub;
                end
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Model: a pending op completes WIDTH+1 edges after the edge that accepted it.
    logic         m_busy = 1'b0, m_done = 1'b0;
    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic [63:0]  m_res = '0;
    int           m_left = 0;

    initial forever begin
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (cancel) begin
                m_busy = 1'b0;
            end else if (!m_busy) begin
                if (hi_we) m_hi = wdata;
                if (lo_we) m_lo = wdata;
                if (start) begin
                    m_res  = ref_res(op, src1, src2);
                    m_busy = 1'b1;
                    m_left = W + 1;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    {m_hi, m_lo} = m_res;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        if (done) done_cnt++;
    end

    task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        op = o; src1 = a; src2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < W + 4) begin
            @(negedge clk);
            n++;
        end
        check({name, " done seen"}, done, 1'b1);
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
        start_op(o, a, b);
        wait_done(name);
        check({name, " hi"}, hi, eh);
        check({name, " lo"}, lo, el);
    endtask

    logic [W-1:0] vals [8] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                               32'h7FFF_FFFF, 32'h7, 32'hFFFF_FFFD, 32'd100};

    initial begin
        int d0;
        repeat (2) @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset hi", hi, '0);
        check("reset lo", lo, '0);
        resetn = 1'b1;

        d0 = done_cnt;
        run_op("mult -3*7", MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        repeat (3) @(negedge clk);
        check("mult single done", 64'(done_cnt - d0), 64'd1);

        run_op("multu max*max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        // Back-to-back: next start issued in the done cycle.
        op = MD_DIVU; src1 = 32'd100; src2 = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("divu 100/7");
        check("divu 100/7 hi", hi, 32'd2);
        check("divu 100/7 lo", lo, 32'd14);
        run_op("div 5/0", MD_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        run_op("div min/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        // Cancel at CALC cycle 10.
        d0 = done_cnt;
        start_op(MD_DIVU, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel busy", busy, 1'b0);
        repeat (W + 4) @(negedge clk);
        check("cancel hi", hi, 32'h0);
        check("cancel lo", lo, 32'h8000_0000);
        check("cancel no done", 64'(done_cnt - d0), 64'd0);
        run_op("multu 6*7", MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

        // mtlo in IDLE, then mthi and start re-pulse while busy.
        @(negedge clk);
        lo_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo lo", lo, 32'h1234);
        start_op(MD_MULTU, 32'd3, 32'd5);
        hi_we = 1'b1; wdata = 32'hDEAD; op = MD_MULT; src1 = 32'd9; src2 = 32'd9; start = 1'b1;
        @(negedge clk);
        hi_we = 1'b0; start = 1'b0;
        wait_done("busy ignore");
        check("busy ignore hi", hi, 32'd0);
        check("busy ignore lo", lo, 32'd15);

        // Asynchronous reset at CALC cycle 5.
        start_op(MD_MULT, 32'hFFFF_FFFD, 32'd7);
        repeat (4) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("areset busy", busy, 1'b0);
        check("areset done", done, 1'b0);
        check("areset hi", hi, '0);
        check("areset lo", lo, '0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        run_op("post reset divu", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        // Corner sweep; the compare process checks every cycle against the model.
        for (int o = 0; o < 4; o++)
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++) begin
                    start_op(2'(o), vals[i], vals[j]);
                    wait_done("sweep");
                end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
